return_address_stack: RTL and testbench

- Hardware return-address stack at the consumer end of the branch/next-address path.
- On a call (jal), it pushes the link address PCAtual+1.
- On a return (jr $ra), it pops that address and hands it back to the fetch stage as the next PC.
- Flush empties it on a context switch, so one process's return addresses never leak into another's.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/ras_storage.sv | 36 +++
 rtl/return_address_stack.sv | 167 ++++++++++++++++
 tb/tb_return_address_stack.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/branch path.
//   PC_W        instruction address width (PC width)
//   addr_t      instruction address type
//   RAS_DEPTH   default return-address stack depth
//   RAS_LVL_W   default width of the stack occupancy count
//   rasLevelWidth(depth)  occupancy-count width able to hold 0..depth
package mips_pkg;

  localparam int PC_W = 11;

  typedef logic [PC_W-1:0] addr_t;

  localparam int RAS_DEPTH = 8;

  function automatic int rasLevelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int RAS_LVL_W = rasLevelWidth(RAS_DEPTH);

endpackage

// File: rtl/ras_storage.sv
// Return-address stack entry array: DEPTH x ADDR_W registers, one
// synchronous write port and one asynchronous read port. Contents are
// intentionally not reset; validity is tracked by the owner's level count.
// Ports:
//   clock   in   write clock
//   we      in   write enable
//   wrIdx   in   write index
//   wrData  in   write data
//   rdIdx   in   read index
//   rdData  out  combinational read data
module ras_storage
  import mips_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [ADDR_W-1:0] wrData,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [ADDR_W-1:0] rdData
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/return_address_stack.sv
// Hardware return-address stack. A call (Push) stores PCAtual+1; a return
// (Pop) hands the top entry back to fetch one cycle later as
// EnderecoRetorno qualified by RetornoValido. Flush empties the stack on a
// context switch; Enable=0 freezes all state.
// Optional build macro RAS_CIRCULAR_EN: storage becomes a circular buffer
// and a push when full overwrites the oldest entry instead of being refused.
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   Enable           in   pipeline advance (0 = stall)
//   Push             in   call executed this cycle
//   Pop              in   return executed this cycle
//   Flush            in   context switch, empties the stack
//   PCAtual          in   PC of the call instruction
//   Topo             out  current top entry (0 when empty)
//   EnderecoRetorno  out  registered address popped last cycle
//   RetornoValido    out  one-cycle strobe qualifying EnderecoRetorno
//   Vazio            out  stack empty
//   Cheio            out  stack full
//   Nivel            out  current occupancy
//   Overflow         out  sticky, a push found the stack full
//   Underflow        out  sticky, a pop found the stack empty
module return_address_stack
  import mips_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int LVL_W  = rasLevelWidth(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Enable,
  input  logic              Push,
  input  logic              Pop,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] PCAtual,
  output logic [ADDR_W-1:0] Topo,
  output logic [ADDR_W-1:0] EnderecoRetorno,
  output logic              RetornoValido,
  output logic              Vazio,
  output logic              Cheio,
  output logic [LVL_W-1:0]  Nivel,
  output logic              Overflow,
  output logic              Underflow
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  levelNext;
  logic              doFlush;
  logic              doPush;
  logic              doPop;
  logic              isEmpty;
  logic              isFull;
  logic              popOk;
  logic              pushOk;
  logic              overflowEvent;
  logic              underflowEvent;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rdIdx;
  logic [ADDR_W-1:0] rdData;
  logic [ADDR_W-1:0] pushValue;

  // Flush outranks the call/return requests of the same cycle.
  assign doFlush = Enable & Flush;
  assign doPush  = Enable & ~Flush & Push;
  assign doPop   = Enable & ~Flush & Pop;

  assign isEmpty = (level == '0);
  assign isFull  = (level == LVL_FULL);

  assign popOk          = doPop & ~isEmpty;
  assign underflowEvent = doPop & isEmpty;
  // A simultaneous successful pop frees the top slot, so only a lone push
  // can hit a full stack.
  assign overflowEvent  = doPush & ~popOk & isFull;

  assign pushValue = PCAtual + ADDR_W'(1);

`ifdef RAS_CIRCULAR_EN
  logic [IDX_W-1:0] topPtr;
  logic [IDX_W-1:0] topPtrNext;

  // Every push is accepted; when full, topPtr+1 is the oldest slot and is
  // overwritten, leaving the level saturated at DEPTH.
  assign pushOk = doPush;
  assign rdIdx  = topPtr;
  assign wrIdx  = popOk ? topPtr : topPtr + IDX_W'(1);

  always_comb begin
    topPtrNext = topPtr;
    if (pushOk && !popOk) begin
      topPtrNext = topPtr + IDX_W'(1);
    end else if (popOk && !pushOk) begin
      topPtrNext = topPtr - IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      topPtr <= '0;
    end else begin
      topPtr <= topPtrNext;
    end
  end
`else
  // Linear stack: entry i lives in slot i, so the top is slot level-1 and
  // the next free slot is slot level.
  assign pushOk = doPush & (popOk | ~isFull);
  assign rdIdx  = IDX_W'(level - LVL_W'(1));
  assign wrIdx  = popOk ? rdIdx : IDX_W'(level);
`endif

  always_comb begin
    levelNext = level;
    if (doFlush) begin
      levelNext = '0;
    end else if (pushOk && !popOk) begin
      levelNext = isFull ? level : level + LVL_W'(1);
    end else if (popOk && !pushOk) begin
      levelNext = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level           <= '0;
      EnderecoRetorno <= '0;
      RetornoValido   <= 1'b0;
      Overflow        <= 1'b0;
      Underflow       <= 1'b0;
    end else begin
      level         <= levelNext;
      RetornoValido <= popOk;
      if (popOk) begin
        EnderecoRetorno <= rdData;
      end
      if (overflowEvent) begin
        Overflow <= 1'b1;
      end
      if (underflowEvent) begin
        Underflow <= 1'b1;
      end
    end
  end

  ras_storage #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uStorage (
    .clock  (clock),
    .we     (pushOk),
    .wrIdx  (wrIdx),
    .wrData (pushValue),
    .rdIdx  (rdIdx),
    .rdData (rdData)
  );

  assign Topo  = isEmpty ? '0 : rdData;
  assign Vazio = isEmpty;
  assign Cheio = isFull;
  assign Nivel = level;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;
  localparam int MODULO = 2048;

  logic              clock;
  logic              reset;
  logic              Enable;
  logic              Push;
  logic              Pop;
  logic              Flush;
  logic [ADDR_W-1:0] PCAtual;
  logic [ADDR_W-1:0] Topo;
  logic [ADDR_W-1:0] EnderecoRetorno;
  logic              RetornoValido;
  logic              Vazio;
  logic              Cheio;
  logic [LVL_W-1:0]  Nivel;
  logic              Overflow;
  logic              Underflow;

  return_address_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .Enable          (Enable),
    .Push            (Push),
    .Pop             (Pop),
    .Flush           (Flush),
    .PCAtual         (PCAtual),
    .Topo            (Topo),
    .EnderecoRetorno (EnderecoRetorno),
    .RetornoValido   (RetornoValido),
    .Vazio           (Vazio),
    .Cheio           (Cheio),
    .Nivel           (Nivel),
    .Overflow        (Overflow),
    .Underflow       (Underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, newest entry at the back.
  int mq[$];
  int mRet   = 0;
  bit mValid = 1'b0;
  bit mOvf   = 1'b0;
  bit mUnf   = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      mRet = 0; mValid = 1'b0; mOvf = 1'b0; mUnf = 1'b0;
    end else if (!Enable) begin
      mValid = 1'b0;
    end else if (Flush) begin
      mq.delete();
      mValid = 1'b0;
    end else begin
      mValid = 1'b0;
      if (Pop) begin
        if (mq.size() == 0) mUnf = 1'b1;
        else begin
          mRet   = mq.pop_back();
          mValid = 1'b1;
        end
      end
      if (Push) begin
        int nv;
        nv = (int'(PCAtual) + 1) % MODULO;
        if (mq.size() < DEPTH) mq.push_back(nv);
        else begin
          mOvf = 1'b1;
`ifdef RAS_CIRCULAR_EN
          void'(mq.pop_front());
          mq.push_back(nv);
`endif
        end
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("Nivel",   int'(Nivel),           mq.size());
      chk("Vazio",   int'(Vazio),           int'(mq.size() == 0));
      chk("Cheio",   int'(Cheio),           int'(mq.size() == DEPTH));
      chk("Topo",    int'(Topo),            (mq.size() == 0) ? 0 : mq[$]);
      chk("RetValid",int'(RetornoValido),   int'(mValid));
      chk("EndRet",  int'(EnderecoRetorno), mRet);
      chk("Ovf",     int'(Overflow),        int'(mOvf));
      chk("Unf",     int'(Underflow),       int'(mUnf));
    end
  end

  task automatic cyc(input bit rst, input bit en, input bit psh, input bit pp,
                     input bit fl, input int pc);
    @(negedge clock);
    reset   = rst;
    Enable  = en;
    Push    = psh;
    Pop     = pp;
    Flush   = fl;
    PCAtual = ADDR_W'(pc);
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input bit psh, input bit pp, input int pc);
    cyc(1'b0, 1'b1, psh, pp, 1'b0, pc);
    settle();
  endtask

  initial begin
    int exp4 [4];
    reset = 1'b1; Enable = 1'b0; Push = 1'b0; Pop = 1'b0; Flush = 1'b0; PCAtual = '0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    settle();
    armed = 1'b1;
    op(1'b0, 1'b0, 0);
    chk("rst_Nivel", int'(Nivel), 0);
    chk("rst_Vazio", int'(Vazio), 1);
    chk("rst_Topo",  int'(Topo), 0);
    chk("rst_RV",    int'(RetornoValido), 0);
    chk("rst_Ovf",   int'(Overflow), 0);
    chk("rst_Unf",   int'(Underflow), 0);

    op(1'b1, 1'b0, 10);
    op(1'b1, 1'b0, 20);
    op(1'b1, 1'b0, 30);
    chk("p3_Topo", int'(Topo), 31);
    op(1'b0, 1'b1, 0);
    chk("pop1_ER", int'(EnderecoRetorno), 31);
    chk("pop1_RV", int'(RetornoValido), 1);
    op(1'b0, 1'b1, 0);
    chk("pop2_ER", int'(EnderecoRetorno), 21);
    op(1'b0, 1'b1, 0);
    chk("pop3_ER", int'(EnderecoRetorno), 11);
    chk("pop3_Vazio", int'(Vazio), 1);

    op(1'b1, 1'b0, 2047);
    chk("wrap_Topo", int'(Topo), 0);
    chk("wrap_Nivel", int'(Nivel), 1);
    op(1'b0, 1'b1, 0);
    chk("wrap_ER", int'(EnderecoRetorno), 0);
    chk("wrap_RV", int'(RetornoValido), 1);

    for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, i);
    chk("full_Cheio", int'(Cheio), 1);
    chk("full_Ovf", int'(Overflow), 1);
`ifdef RAS_CIRCULAR_EN
    exp4 = '{6, 5, 4, 3};
`else
    exp4 = '{5, 4, 3, 2};
`endif
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 0);
      chk("full_pop_ER", int'(EnderecoRetorno), exp4[i]);
    end
    chk("full_Vazio", int'(Vazio), 1);

    op(1'b1, 1'b0, 10);
    op(1'b1, 1'b0, 20);
    op(1'b1, 1'b1, 40);
    chk("pp_ER", int'(EnderecoRetorno), 21);
    chk("pp_RV", int'(RetornoValido), 1);
    chk("pp_Nivel", int'(Nivel), 2);
    chk("pp_Topo", int'(Topo), 41);

    op(1'b1, 1'b0, 60);
    chk("pre_flush_Nivel", int'(Nivel), 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 100);
    settle();
    chk("flush_Nivel", int'(Nivel), 0);
    chk("flush_Topo", int'(Topo), 0);
    op(1'b1, 1'b0, 7);
    chk("post_flush_Nivel", int'(Nivel), 1);
    chk("post_flush_Topo", int'(Topo), 8);
    op(1'b0, 1'b1, 0);
    chk("post_flush_ER", int'(EnderecoRetorno), 8);
    op(1'b0, 1'b1, 0);
    chk("unf_flag", int'(Underflow), 1);
    chk("unf_RV", int'(RetornoValido), 0);
    chk("unf_ER", int'(EnderecoRetorno), 8);

    op(1'b1, 1'b0, 50);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    settle();
    chk("stall_Nivel", int'(Nivel), 1);
    chk("stall_Topo", int'(Topo), 51);
    chk("stall_RV", int'(RetornoValido), 0);

    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    settle();
    chk("mrst_Nivel", int'(Nivel), 0);
    chk("mrst_Topo", int'(Topo), 0);
    chk("mrst_ER", int'(EnderecoRetorno), 0);
    chk("mrst_Ovf", int'(Overflow), 0);
    chk("mrst_Unf", int'(Underflow), 0);

    for (int i = 0; i < 3000; i++) begin
      bit rst, en, psh, pp, fl;
      int pc;
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      psh = ($urandom_range(0, 99) < 55);
      pp  = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 29) == 0);
      pc  = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 2047));
      cyc(rst, en, psh, pp, fl, pc);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
